// File: rtl/bcd_display_scan_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the two-digit seven-segment scan driver:
//   - scan FSM state encoding
//   - seven-segment codes (active-high, bit order g f e d c b a)
//   - BCD digit width
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_U = 2'd1,
        SHOW_T = 2'd2
    } state_t;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scan_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to seven-segment decoder. Codes above 9 are not valid
// BCD and are shown as a dash so a bad adder result is visible on the board.
// Ports:
//   i_bcd : BCD digit in
//   o_seg : segment pattern out, active-high, g f e d c b a
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [SEG_W-1:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// ---------------------------------------------------------------------------
// bcd_display_scan
// Two-digit multiplexed seven-segment driver. Captures the tens/units BCD
// pair on a load strobe and alternates the two digits on a shared segment
// bus, REFRESH_DIV cycles per digit. A zero tens digit is blanked.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   load  : one-cycle strobe, captures s1/s0
//   clear : synchronous return to blank idle (beats load)
//   s1,s0 : tens / units BCD digits
//   seg   : segment drive, active-high, g f e d c b a
//   an    : one-hot digit enable, bit1 = tens, bit0 = units
//   ack   : one-cycle pulse after an accepted load
// Outputs are registered from the next-state values, so the display shows
// the post-edge state with no extra cycle of lag.
// ---------------------------------------------------------------------------
module bcd_display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [BCD_W-1:0] s1,
    input  logic [BCD_W-1:0] s0,
    output logic [SEG_W-1:0] seg,
    output logic [1:0]       an,
    output logic             ack
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic [BCD_W-1:0]   r_d1,    w_d1_nxt;
    logic [BCD_W-1:0]   r_d0,    w_d0_nxt;
    logic               r_ack,   w_ack_nxt;
    logic [SEG_W-1:0]   r_seg,   w_seg_nxt;
    logic [1:0]         r_an,    w_an_nxt;

    logic [BCD_W-1:0]   w_digit;
    logic [SEG_W-1:0]   w_dec;

    // State register: FSM, counter, digits and outputs all move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_d1    <= '0;
            r_d0    <= '0;
            r_ack   <= 1'b0;
            r_seg   <= SEG_BLANK;
            r_an    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_d1    <= w_d1_nxt;
            r_d0    <= w_d0_nxt;
            r_ack   <= w_ack_nxt;
            r_seg   <= w_seg_nxt;
            r_an    <= w_an_nxt;
        end
    end

    // Next-state logic. A load while scanning only swaps the digits; the
    // scan schedule keeps running so the refresh rate never jitters.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_d1_nxt    = r_d1;
        w_d0_nxt    = r_d0;
        w_ack_nxt   = 1'b0;
        if (clear) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_d1_nxt    = '0;
            w_d0_nxt    = '0;
        end else begin
            if (load) begin
                w_d1_nxt  = s1;
                w_d0_nxt  = s0;
                w_ack_nxt = 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (load) begin
                        w_state_nxt = SHOW_U;
                        w_cnt_nxt   = '0;
                    end
                end
                SHOW_U: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = SHOW_T;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                SHOW_T: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = SHOW_U;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Decode the digit that will be on display after this edge.
    assign w_digit = (w_state_nxt == SHOW_T) ? w_d1_nxt : w_d0_nxt;

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

    // Output logic. Only an exact zero tens digit is blanked; 10-15 keep
    // the enable on so the dash is visible.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_an_nxt  = 2'b00;
        case (w_state_nxt)
            SHOW_U: begin
                w_an_nxt  = 2'b01;
                w_seg_nxt = w_dec;
            end
            SHOW_T: begin
                if (w_d1_nxt != '0) begin
                    w_an_nxt  = 2'b10;
                    w_seg_nxt = w_dec;
                end
            end
            default: begin
                w_seg_nxt = SEG_BLANK;
                w_an_nxt  = 2'b00;
            end
        endcase
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign ack = r_ack;

endmodule

// File: tb/tb_bcd_display_scan.sv
module tb_bcd_display_scan;

    logic       clk = 1'b0;
    logic       rst, load, clear;
    logic [3:0] s1, s0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_display_scan #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .clear (clear),
        .s1    (s1),
        .s0    (s0),
        .seg   (seg),
        .an    (an),
        .ack   (ack)
    );

    // One clock cycle: inputs held during the cycle, expected outputs
    // after the following rising edge.
    typedef struct {
        string      tag;
        logic       rst, load, clear;
        logic [3:0] s1, s0;
        logic [6:0] seg;
        logic [1:0] an;
        logic       ack;
    } vec_t;

    typedef struct {
        string      tag;
        logic [6:0] seg;
        logic [1:0] an;
        logic       ack;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic add(input string tag, input logic r, input logic l, input logic c,
                       input logic [3:0] a1, input logic [3:0] a0,
                       input logic [6:0] sg, input logic [1:0] a, input logic k);
        vec_t v;
        v.tag = tag; v.rst = r; v.load = l; v.clear = c; v.s1 = a1; v.s0 = a0;
        v.seg = sg; v.an = a; v.ack = k;
        vecs.push_back(v);
    endtask

    // n quiet cycles with a fixed expected display
    task automatic hold(input string tag, input int n, input logic [6:0] sg, input logic [1:0] a);
        for (int i = 0; i < n; i++) add(tag, 0, 0, 0, 4'd0, 4'd0, sg, a, 0);
    endtask

    task automatic check(input exp_t e);
        n_tests++;
        if (seg !== e.seg || an !== e.an || ack !== e.ack) begin
            n_fail++;
            $display("FAIL %s: got seg=%h an=%b ack=%b, want seg=%h an=%b ack=%b",
                     e.tag, seg, an, ack, e.seg, e.an, e.ack);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; load = v.load; clear = v.clear; s1 = v.s1; s0 = v.s0;
        e.tag = v.tag; e.seg = v.seg; e.an = v.an; e.ack = v.ack;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(exp_q.pop_front());
    endtask

    // The digit enable must never select both digits.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_tests++;
            if (an === 2'b11) begin
                n_fail++;
                $display("FAIL an_onehot: got an=%b, want not 11", an);
            end
        end
    end

    initial begin
        vec_t v;
        rst = 1; load = 0; clear = 0; s1 = 0; s0 = 0;

        // reset, then idle
        add("reset", 1, 0, 0, 0, 0, 7'h00, 2'b00, 0);
        add("reset", 1, 0, 0, 0, 0, 7'h00, 2'b00, 0);
        hold("idle", 10, 7'h00, 2'b00);

        // basic load 18: units 8, tens 1
        add("load18", 0, 1, 0, 4'd1, 4'd8, 7'h7F, 2'b01, 1);
        hold("u8", 3, 7'h7F, 2'b01);
        hold("t1", 4, 7'h06, 2'b10);
        hold("u8_rep", 4, 7'h7F, 2'b01);
        hold("t1_rep", 4, 7'h06, 2'b10);

        // mid-scan reload at cycle 2 of units slot; slot keeps its schedule
        hold("u8_c1", 1, 7'h7F, 2'b01);
        add("reload03", 0, 1, 0, 4'd0, 4'd3, 7'h4F, 2'b01, 1);
        hold("u3", 2, 7'h4F, 2'b01);
        hold("t0_blank", 4, 7'h00, 2'b00);
        hold("u3_rep", 4, 7'h4F, 2'b01);

        // clear beats load
        add("clr_load", 0, 1, 1, 4'd5, 4'd5, 7'h00, 2'b00, 0);
        hold("clr_idle", 3, 7'h00, 2'b00);

        // leading-zero blank
        add("load05", 0, 1, 0, 4'd0, 4'd5, 7'h6D, 2'b01, 1);
        hold("u5", 3, 7'h6D, 2'b01);
        hold("t0_blank", 4, 7'h00, 2'b00);

        // invalid codes show dash, tens enabled
        add("clr", 0, 0, 1, 4'd0, 4'd0, 7'h00, 2'b00, 0);
        add("load_inv", 0, 1, 0, 4'd12, 4'd10, 7'h40, 2'b01, 1);
        hold("u_dash", 3, 7'h40, 2'b01);
        hold("t_dash", 4, 7'h40, 2'b10);

        // back-to-back loads, then a load on the terminal count
        add("b2b_a", 0, 1, 0, 4'd9, 4'd9, 7'h6F, 2'b01, 1);
        add("b2b_b", 0, 1, 0, 4'd2, 4'd7, 7'h07, 2'b01, 1);
        hold("u7", 2, 7'h07, 2'b01);
        hold("t2", 4, 7'h5B, 2'b10);
        add("load_tc", 0, 1, 0, 4'd4, 4'd0, 7'h3F, 2'b01, 1);
        hold("u0", 3, 7'h3F, 2'b01);
        hold("t4", 2, 7'h66, 2'b10);

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);

        // Hand-written: reset mid-SHOW_T, next load restarts in SHOW_U
        v = '{tag: "rst_mid", rst: 1, load: 0, clear: 0, s1: 0, s0: 0, seg: 7'h00, an: 2'b00, ack: 0};
        drive(v);
        v = '{tag: "post_rst", rst: 0, load: 0, clear: 0, s1: 0, s0: 0, seg: 7'h00, an: 2'b00, ack: 0};
        drive(v);
        drive(v);
        v = '{tag: "load31", rst: 0, load: 1, clear: 0, s1: 3, s0: 1, seg: 7'h06, an: 2'b01, ack: 1};
        drive(v);
        for (int i = 0; i < 3; i++) begin
            v = '{tag: "u1", rst: 0, load: 0, clear: 0, s1: 0, s0: 0, seg: 7'h06, an: 2'b01, ack: 0};
            drive(v);
        end
        for (int i = 0; i < 4; i++) begin
            v = '{tag: "t3", rst: 0, load: 0, clear: 0, s1: 0, s0: 0, seg: 7'h4F, an: 2'b10, ack: 0};
            drive(v);
        end

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
